// File: rtl/online_div_pkg.sv
// Shared definitions for the online divider digit-buffer path.
package online_div_pkg;

  // Digit and RAM geometry of the 128x4 digit RAM.
  localparam int DIGIT_W = 4;
  localparam int RAM_AW  = 7;

  // Buffer controller phases.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

endpackage

// File: rtl/online_ptr_ctr.sv
// Wrapping RAM pointer: increments on enable, modulo 2**ADDR_WIDTH,
// with a synchronous clear used when a new stream starts.
module online_ptr_ctr
  import online_div_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_AW
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_en,
  output logic [ADDR_WIDTH-1:0] o_cnt
);

  logic [ADDR_WIDTH-1:0] r_cnt;

  // Counter wraps naturally through the width of r_cnt.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + ADDR_WIDTH'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/online_digit_buffer_ctrl.sv
// Digit buffer controller in front of the 128x4 digit RAM. Writes the
// incoming online digit stream at wrapping addresses and replays it in
// order once ONLINE_DELAY+1 digits are buffered (or the stream ended).
module online_digit_buffer_ctrl
  import online_div_pkg::*;
#(
  parameter int DATA_WIDTH   = DIGIT_W,
  parameter int ADDR_WIDTH   = RAM_AW,
  parameter int ONLINE_DELAY = 3
) (
  input  logic                  clk,
  input  logic                  async_clear,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_digit,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_digit,
  input  logic                  out_ready,
  output logic                  done,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int                DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] OCC_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] OCC_GO   = (ADDR_WIDTH+1)'(ONLINE_DELAY + 1);
  localparam logic [ADDR_WIDTH:0] OCC_ONE  = (ADDR_WIDTH+1)'(1);

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_occ;
  logic                  r_last_seen;
  logic                  r_done;

  logic [ADDR_WIDTH-1:0] w_wr_ptr;
  logic [ADDR_WIDTH-1:0] w_rd_ptr;
  logic                  w_accepting;
  logic                  w_replaying;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_last_acc;
  logic                  w_ptr_clr;
  logic [ADDR_WIDTH:0]   w_occ_nxt;

  // Handshakes are functions of registered state and occupancy only, so a
  // digit written at one edge is never offered before the next cycle.
  assign w_accepting = (r_state == ST_FILL) || (r_state == ST_STREAM);
  assign w_replaying = (r_state == ST_STREAM) || (r_state == ST_DRAIN);

  assign in_ready   = w_accepting && (r_occ < OCC_FULL);
  assign out_valid  = w_replaying && (r_occ != '0);
  assign w_wr_fire  = in_valid && in_ready;
  assign w_rd_fire  = out_valid && out_ready;
  assign w_last_acc = w_wr_fire && in_last;
  assign w_ptr_clr  = (r_state == ST_IDLE) && start;

  // Occupancy after this edge: +1 write, -1 read, unchanged if both fire.
  always_comb begin
    w_occ_nxt = r_occ;
    if (w_wr_fire && !w_rd_fire)      w_occ_nxt = r_occ + OCC_ONE;
    else if (!w_wr_fire && w_rd_fire) w_occ_nxt = r_occ - OCC_ONE;
  end

  online_ptr_ctr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .i_clk (clk),
    .i_rst (async_clear),
    .i_clr (w_ptr_clr),
    .i_en  (w_wr_fire),
    .o_cnt (w_wr_ptr)
  );

  online_ptr_ctr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .i_clk (clk),
    .i_rst (async_clear),
    .i_clr (w_ptr_clr),
    .i_en  (w_rd_fire),
    .o_cnt (w_rd_ptr)
  );

  // Stream sequencing: fill to the online delay, stream, then drain to empty.
  always_ff @(posedge clk or posedge async_clear) begin
    if (async_clear) begin
      r_state     <= ST_IDLE;
      r_occ       <= '0;
      r_last_seen <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_FILL;
            r_occ       <= '0;
            r_last_seen <= 1'b0;
          end
        end
        ST_FILL: begin
          r_occ <= w_occ_nxt;
          // A stream shorter than the delay drains without ever streaming.
          if (w_last_acc) begin
            r_last_seen <= 1'b1;
            r_state     <= ST_DRAIN;
          end else if (w_occ_nxt >= OCC_GO) begin
            r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          r_occ <= w_occ_nxt;
          if (w_last_acc) begin
            r_last_seen <= 1'b1;
            r_state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_occ <= w_occ_nxt;
          if (r_last_seen && (w_occ_nxt == '0)) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign done = r_done;
  assign busy = (r_state != ST_IDLE);

  // RAM side. The read address runs one ahead on a read fire so that the
  // 1-cycle RAM presents mem[rd_ptr] every cycle with no bubbles; a stall
  // re-presents rd_ptr and holds out_digit steady.
  assign ram_data       = in_digit;
  assign ram_write_addr = w_wr_ptr;
  assign ram_we         = w_wr_fire;
  assign ram_read_addr  = w_rd_ptr + ADDR_WIDTH'(w_rd_fire);
  assign out_digit      = ram_q;

endmodule

// File: tb/tb_online_digit_buffer_ctrl.sv
// Randomized bench for online_digit_buffer_ctrl against a queue-based model.
module tb_online_digit_buffer_ctrl;

  localparam int DW    = 4;
  localparam int AW    = 7;
  localparam int DELAY = 3;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          async_clear;
  logic          start, in_valid, in_last, out_ready;
  logic [DW-1:0] in_digit;
  logic          in_ready, out_valid, done, busy, ram_we;
  logic [DW-1:0] out_digit, ram_data, ram_q;
  logic [AW-1:0] ram_write_addr, ram_read_addr;

  always #5 clk = ~clk;

  online_digit_buffer_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ONLINE_DELAY(DELAY)
  ) dut (
    .clk(clk), .async_clear(async_clear), .start(start),
    .in_valid(in_valid), .in_digit(in_digit), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_digit(out_digit),
    .out_ready(out_ready), .done(done), .busy(busy),
    .ram_data(ram_data), .ram_write_addr(ram_write_addr), .ram_we(ram_we),
    .ram_read_addr(ram_read_addr), .ram_q(ram_q)
  );

  // Digit RAM: address registered, data shows current contents.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] raddr_q;
  always @(posedge clk or posedge async_clear) begin
    if (async_clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      raddr_q <= '0;
    end else begin
      if (ram_we) mem[ram_write_addr] <= ram_data;
      raddr_q <= ram_read_addr;
    end
  end
  assign ram_q = mem[raddr_q];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference model: buffered digits as a queue plus stream bookkeeping.
  logic [DW-1:0] m_q[$];
  bit m_active, m_last, m_done;
  int m_nwr, m_nrd;

  int g_cyc, g_first_ov, g_fill_cyc, g_done_cnt, g_we_cnt;
  bit g_wf;

  task automatic model_reset();
    m_q.delete();
    m_active = 0; m_last = 0; m_done = 0; m_nwr = 0; m_nrd = 0;
  endtask

  // One clock: inputs were driven at the falling edge; check, then advance.
  task automatic cycle();
    bit e_ir, e_ov, wf, rf;
    #1;
    e_ir = m_active && !m_last && (m_q.size() < DEPTH);
    e_ov = m_active && (m_last || m_nwr >= DELAY + 1) && (m_q.size() > 0);
    wf = in_valid && e_ir;
    rf = e_ov && out_ready;
    chk("in_ready", 32'(in_ready), 32'(e_ir));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("ram_we", 32'(ram_we), 32'(wf));
    chk("done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_active));
    chk("wr_addr", 32'(ram_write_addr), 32'(m_nwr % DEPTH));
    chk("rd_addr", 32'(ram_read_addr), 32'((m_nrd + int'(rf)) % DEPTH));
    if (e_ov) chk("out_digit", 32'(out_digit), 32'(m_q[0]));
    if (wf) chk("ram_data", 32'(ram_data), 32'(in_digit));
    if (out_valid && g_first_ov < 0) g_first_ov = g_cyc;
    if (wf && m_nwr + 1 == DELAY + 1) g_fill_cyc = g_cyc;
    if (done) g_done_cnt++;
    if (ram_we) g_we_cnt++;
    g_wf = wf;
    @(posedge clk);
    m_done = 0;
    if (!m_active) begin
      if (start) begin
        m_active = 1; m_last = 0; m_nwr = 0; m_nrd = 0; m_q.delete();
      end
    end else begin
      if (wf) begin
        m_q.push_back(in_digit);
        m_nwr++;
        if (in_last) m_last = 1;
      end
      if (rf) begin
        void'(m_q.pop_front());
        m_nrd++;
      end
      if (m_last && m_q.size() == 0) begin
        m_active = 0;
        m_done = 1;
      end
    end
    g_cyc++;
    @(negedge clk);
  endtask

  // Drive one complete stream of n digits; p_in/p_out are percent rates,
  // hold forces out_ready low for the first cycles, tog alternates out_ready.
  task automatic run_stream(input int n, input int p_in, input int p_out,
                            input int hold, input bit tog, input bit seq);
    int idx = 0;
    int budget;
    int hold_left = hold;
    bit hold_checked = 0;
    g_first_ov = -1; g_fill_cyc = -1; g_done_cnt = 0; g_we_cnt = 0;
    start = 1; in_valid = 0; in_last = 0;
    cycle();
    start = 0;
    budget = n * 40 + hold + 400;
    while (m_active && budget > 0) begin
      if (idx < n) begin
        in_valid = ($urandom_range(99) < p_in);
        in_digit = seq ? DW'(idx + 1) : DW'($urandom);
        in_last  = (idx == n - 1);
      end else begin
        in_valid = $urandom_range(1);
        in_digit = DW'($urandom);
        in_last  = $urandom_range(1);
      end
      if (hold_left > 0) begin
        out_ready = 0;
        hold_left--;
      end else if (tog) out_ready = ~out_ready;
      else out_ready = ($urandom_range(99) < p_out);
      start = ($urandom_range(15) == 0);
      cycle();
      if (g_wf) idx++;
      if (hold > 0 && !hold_checked && hold_left == 0) begin
        chk("full_we_count", 32'(g_we_cnt), 32'(DEPTH));
        chk("full_blocked", 32'(in_ready), 32'(0));
        hold_checked = 1;
      end
      budget--;
    end
    if (budget <= 0) chk("stream_timeout", 32'(0), 32'(1));
    start = 0; in_valid = 0; in_last = 0;
    cycle();
    chk("done_pulses", 32'(g_done_cnt), 32'(1));
    chk("idle_after", 32'(busy), 32'(0));
  endtask

  initial begin
    model_reset();
    g_cyc = 0;
    async_clear = 1; start = 0; in_valid = 0; in_last = 0; in_digit = '0; out_ready = 0;
    #23;
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_rd_addr", 32'(ram_read_addr), 32'(0));
    @(negedge clk);
    async_clear = 0;
    cycle();

    // 8 digits 0x1..0x8, full rate, first output one cycle after 4th write.
    out_ready = 1;
    run_stream(8, 100, 100, 0, 0, 1);
    chk("first_ov_latency", 32'(g_first_ov - g_fill_cyc), 32'(1));

    // Alternating backpressure.
    out_ready = 0;
    run_stream(40, 80, 0, 0, 1, 0);

    // Fill to 128 with output stalled, then release.
    run_stream(200, 100, 100, 140, 0, 0);

    // Long stream crossing the pointer wrap several times.
    run_stream(300, 100, 100, 0, 0, 1);

    // Single-digit stream.
    start = 1; cycle(); start = 0;
    in_valid = 1; in_digit = 4'hA; in_last = 1; out_ready = 1;
    cycle();
    in_valid = 0; in_last = 0;
    chk("short_ov", 32'(out_valid), 32'(1));
    chk("short_digit", 32'(out_digit), 32'(4'hA));
    cycle();
    chk("short_done", 32'(done), 32'(1));
    cycle();

    // Clear in the middle of a stream with 5 digits buffered.
    start = 1; cycle(); start = 0;
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_last = 0; in_digit = DW'($urandom);
      cycle();
    end
    in_valid = 0;
    chk("mid_occ_model", 32'(m_q.size()), 32'(5));
    #2 async_clear = 1;
    #1;
    chk("clr_in_ready", 32'(in_ready), 32'(0));
    chk("clr_out_valid", 32'(out_valid), 32'(0));
    chk("clr_done", 32'(done), 32'(0));
    chk("clr_busy", 32'(busy), 32'(0));
    chk("clr_we", 32'(ram_we), 32'(0));
    chk("clr_rd_addr", 32'(ram_read_addr), 32'(0));
    chk("clr_wr_addr", 32'(ram_write_addr), 32'(0));
    model_reset();
    @(negedge clk);
    async_clear = 0;
    run_stream(20, 90, 90, 0, 0, 1);

    // Random streams, including degenerate lengths.
    run_stream(1, 50, 50, 0, 0, 0);
    for (int k = 0; k < 6; k++)
      run_stream($urandom_range(60, 1), $urandom_range(100, 30),
                 $urandom_range(100, 30), 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
